// File: rtl/ddr_lane_engine.sv
// rtl/ddr_lane_engine.sv - DDR lane engine: arrow spawn/scroll, hit judgement, score/streak/miss.
// Optional DDR_LFSR_SPAWN_EN selects the spawn lane from an 8-bit Galois LFSR instead of round-robin.
module ddr_lane_engine #(
  parameter int LANES     = 4,
  parameter int CORDW     = 10,
  parameter int Y_START   = 480,
  parameter int SPEED     = 7,
  parameter int TARGET_Y  = 40,
  parameter int HIT_WIN   = 12,
  parameter int SPAWN_GAP = 20,
  parameter int SCOREW    = 12,
  parameter int MAX_MISS  = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     start_i,
  input  logic                     frame_i,
  input  logic [LANES-1:0]         btn_i,
  output logic [LANES*CORDW-1:0]   arrow_y_o,
  output logic [LANES-1:0]         arrow_active_o,
  output logic [SCOREW-1:0]        score_o,
  output logic [SCOREW-1:0]        streak_o,
  output logic [7:0]               miss_cnt_o,
  output logic [LANES-1:0]         hit_o,
  output logic [LANES-1:0]         miss_o,
  output logic                     game_over_o
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
  localparam logic [CORDW-1:0] YS = CORDW'(Y_START);
  localparam logic signed [CORDW:0] TGT = (CORDW+1)'(TARGET_Y);
  localparam logic signed [CORDW:0] WIN = (CORDW+1)'(HIT_WIN);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t                        state;
  logic [LANES-1:0][CORDW-1:0]   y_q, y_nx;
  logic [LANES-1:0]              act_q, act_nx, hit_nx, miss_nx;
  logic [GW-1:0]                 gap_cnt;
  logic [LW-1:0]                 spawn_lane;
  logic                          spawn_now;
  logic [3:0]                    n_hit, n_miss;
  logic [SCOREW:0]               score_sum, streak_sum;
  logic [SCOREW-1:0]             score_nx, streak_nx;
  logic [8:0]                    miss_sum;
  logic [7:0]                    miss_nx_cnt;
  logic signed [CORDW:0]         dy;
`ifdef DDR_LFSR_SPAWN_EN
  logic [7:0]                    lfsr_q;
  assign spawn_lane = LW'(lfsr_q % 8'(LANES));
`else
  logic [LW-1:0]                 sel_q;
  assign spawn_lane = sel_q;
`endif

  assign arrow_y_o      = y_q;
  assign arrow_active_o = act_q;
  assign spawn_now      = frame_i && (gap_cnt == GW'(SPAWN_GAP - 1));

  // Press judgement uses pre-move Y; a hit suppresses this frame's move/expiry.
  always_comb begin
    y_nx    = y_q;
    act_nx  = act_q;
    hit_nx  = '0;
    miss_nx = '0;
    n_hit   = '0;
    n_miss  = '0;
    dy      = '0;
    for (int l = 0; l < LANES; l++) begin
      dy = $signed({1'b0, y_q[l]}) - TGT;
      if (btn_i[l]) begin
        if (act_q[l] && (dy <= WIN) && (dy >= -WIN)) begin
          hit_nx[l] = 1'b1;
          act_nx[l] = 1'b0;
          y_nx[l]   = YS;
        end else begin
          miss_nx[l] = 1'b1;
        end
      end
      if (frame_i && act_q[l] && !hit_nx[l]) begin
        if (y_q[l] < CORDW'(SPEED + 1)) begin
          act_nx[l]  = 1'b0;
          miss_nx[l] = 1'b1;
        end else begin
          y_nx[l] = y_q[l] - CORDW'(SPEED);
        end
      end
      if (spawn_now && (spawn_lane == LW'(l)) && !act_q[l]) begin
        act_nx[l] = 1'b1;
        y_nx[l]   = YS;
      end
      n_hit  = n_hit + 4'(hit_nx[l]);
      n_miss = n_miss + 4'(miss_nx[l]);
    end
    score_sum   = {1'b0, score_o} + (SCOREW+1)'(n_hit);
    streak_sum  = {1'b0, streak_o} + (SCOREW+1)'(n_hit);
    score_nx    = score_sum[SCOREW] ? '1 : score_sum[SCOREW-1:0];
    streak_nx   = (n_miss != 4'd0) ? '0 :
                  (streak_sum[SCOREW] ? '1 : streak_sum[SCOREW-1:0]);
    miss_sum    = {1'b0, miss_cnt_o} + 9'(n_miss);
    miss_nx_cnt = (miss_sum >= 9'(MAX_MISS)) ? 8'(MAX_MISS) : miss_sum[7:0];
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      y_q         <= {LANES{YS}};
      act_q       <= '0;
      score_o     <= '0;
      streak_o    <= '0;
      miss_cnt_o  <= '0;
      hit_o       <= '0;
      miss_o      <= '0;
      game_over_o <= 1'b0;
      gap_cnt     <= '0;
`ifdef DDR_LFSR_SPAWN_EN
      lfsr_q      <= 8'h01;
`else
      sel_q       <= '0;
`endif
    end else begin
      hit_o  <= '0;
      miss_o <= '0;
      case (state)
        IDLE, OVER: begin
          if (start_i) begin
            state       <= PLAY;
            y_q         <= {LANES{YS}};
            act_q       <= '0;
            score_o     <= '0;
            streak_o    <= '0;
            miss_cnt_o  <= '0;
            game_over_o <= 1'b0;
            gap_cnt     <= '0;
`ifdef DDR_LFSR_SPAWN_EN
            lfsr_q      <= 8'h01;
`else
            sel_q       <= '0;
`endif
          end
        end
        PLAY: begin
          y_q        <= y_nx;
          act_q      <= act_nx;
          hit_o      <= hit_nx;
          miss_o     <= miss_nx;
          score_o    <= score_nx;
          streak_o   <= streak_nx;
          miss_cnt_o <= miss_nx_cnt;
          if (frame_i) begin
            gap_cnt <= spawn_now ? '0 : gap_cnt + 1'b1;
          end
          if (spawn_now) begin
`ifdef DDR_LFSR_SPAWN_EN
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
`else
            sel_q <= (sel_q == LW'(LANES - 1)) ? '0 : sel_q + 1'b1;
`endif
          end
          if (miss_nx_cnt == 8'(MAX_MISS)) begin
            state       <= OVER;
            game_over_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_lane_engine.sv
// tb/tb_ddr_lane_engine.sv - directed self-checking bench for ddr_lane_engine.
module tb_ddr_lane_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance a: default parameters
  logic        start_a, frame_a;
  logic [3:0]  btn_a;
  logic [39:0] y_a;
  logic [3:0]  act_a, hit_a, miss_a;
  logic [11:0] score_a, streak_a;
  logic [7:0]  mcnt_a;
  logic        over_a;

  // Instance b: two lanes spawning every frame; instance c: one lane spawning every frame
  logic        start_bc, frame_bc;
  logic [1:0]  btn_b;
  logic [0:0]  btn_c;
  logic [19:0] y_b;
  logic [1:0]  act_b, hit_b, miss_b;
  logic [11:0] score_b, streak_b;
  logic [7:0]  mcnt_b;
  logic        over_b;
  logic [9:0]  y_c;
  logic [0:0]  act_c, hit_c, miss_c;
  logic [11:0] score_c, streak_c;
  logic [7:0]  mcnt_c;
  logic        over_c;

  ddr_lane_engine u_a (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_a), .frame_i(frame_a), .btn_i(btn_a),
    .arrow_y_o(y_a), .arrow_active_o(act_a), .score_o(score_a), .streak_o(streak_a),
    .miss_cnt_o(mcnt_a), .hit_o(hit_a), .miss_o(miss_a), .game_over_o(over_a)
  );

  ddr_lane_engine #(.LANES(2), .SPAWN_GAP(1)) u_b (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_bc), .frame_i(frame_bc), .btn_i(btn_b),
    .arrow_y_o(y_b), .arrow_active_o(act_b), .score_o(score_b), .streak_o(streak_b),
    .miss_cnt_o(mcnt_b), .hit_o(hit_b), .miss_o(miss_b), .game_over_o(over_b)
  );

  ddr_lane_engine #(.LANES(1), .SPAWN_GAP(1)) u_c (
    .clk_i(clk), .reset_ni(rst_n), .start_i(start_bc), .frame_i(frame_bc), .btn_i(btn_c),
    .arrow_y_o(y_c), .arrow_active_o(act_c), .score_o(score_c), .streak_o(streak_c),
    .miss_cnt_o(mcnt_c), .hit_o(hit_c), .miss_o(miss_c), .game_over_o(over_c)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames_a(input int n);
    frame_a = 1'b1;
    repeat (n) tick();
    frame_a = 1'b0;
  endtask

  task automatic frames_bc(input int n);
    frame_bc = 1'b1;
    repeat (n) tick();
    frame_bc = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; frame_a = 1'b0; btn_a = '0;
    start_bc = 1'b0; frame_bc = 1'b0; btn_b = '0; btn_c = '0;
    repeat (2) tick();
    check("rst_y", y_a, {4{10'd480}});
    check("rst_act", act_a, 0);
    check("rst_over", over_a, 0);
    check("rst_mcnt", mcnt_a, 0);
    rst_n = 1'b1;
    tick();

    start_a = 1'b1; tick(); start_a = 1'b0;
    frames_a(19);
    check("no_spawn_19", act_a, 0);
    frames_a(1);
    check("spawn20_act", act_a, 4'b0001);
    check("spawn20_y", y_a, {10'd480, 10'd480, 10'd480, 10'd480});
    frames_a(1);
    check("move21_y0", y_a[9:0], 473);

    btn_a = 4'b0001; tick(); btn_a = '0;
    check("early_miss", miss_a, 4'b0001);
    check("early_mcnt", mcnt_a, 1);
    check("early_streak", streak_a, 0);
    check("early_act", act_a, 4'b0001);
    frames_a(1);
    check("keep_scroll", y_a[9:0], 466);
    check("miss_pulse_clr", miss_a, 0);

    frames_a(61);
    check("y_at_39", y_a, {10'd459, 10'd319, 10'd179, 10'd39});
    check("all_active", act_a, 4'b1111);
    btn_a = 4'b0001; tick(); btn_a = '0;
    check("hit_pulse", hit_a, 4'b0001);
    check("hit_score", score_a, 1);
    check("hit_streak", streak_a, 1);
    check("hit_act", act_a, 4'b1110);
    check("hit_y", y_a, {10'd459, 10'd319, 10'd179, 10'd480});

    start_a = 1'b1; tick(); start_a = 1'b0;
    check("start_in_play", score_a, 1);

    frames_a(25);
    check("pre_expire_y", y_a, {10'd284, 10'd144, 10'd4, 10'd424});
    check("pre_expire_act", act_a, 4'b1111);
    frames_a(1);
    check("expire_miss", miss_a, 4'b0010);
    check("expire_act", act_a, 4'b1101);
    check("expire_mcnt", mcnt_a, 2);

    btn_a = 4'b1111; tick();
    check("multi_miss", miss_a, 4'b1111);
    check("multi_mcnt", mcnt_a, 6);
    check("not_over_yet", over_a, 0);
    tick(); btn_a = '0;
    check("final_miss", miss_a, 4'b1111);
    check("sat_mcnt", mcnt_a, 8);
    check("game_over", over_a, 1);

    frame_a = 1'b1; btn_a = 4'b1111;
    repeat (5) tick();
    frame_a = 1'b0; btn_a = '0;
    check("frozen_y", y_a, {10'd277, 10'd137, 10'd4, 10'd417});
    check("frozen_act", act_a, 4'b1101);
    check("frozen_miss", miss_a, 0);
    check("frozen_mcnt", mcnt_a, 8);

    start_a = 1'b1; tick(); start_a = 1'b0;
    check("restart_over", over_a, 0);
    check("restart_score", score_a, 0);
    check("restart_mcnt", mcnt_a, 0);
    check("restart_act", act_a, 0);
    check("restart_y", y_a, {4{10'd480}});
    frames_a(20);
    check("respawn_act", act_a, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_act", act_a, 0);
    check("async_rst_y", y_a, {4{10'd480}});
    tick();
    rst_n = 1'b1;
    tick();

    start_bc = 1'b1; tick(); start_bc = 1'b0;
    frames_bc(1);
    check("c_spawn", y_c, 480);
    frames_bc(1);
    check("c_drop_y", y_c, 473);
    check("c_drop_act", act_c, 1);
    check("b_two_y", y_b, {10'd480, 10'd473});
    frames_bc(62);
    check("b_window_y", y_b, {10'd46, 10'd39});
    check("b_window_act", act_b, 2'b11);
    btn_b = 2'b11; frame_bc = 1'b1; tick(); btn_b = '0; frame_bc = 1'b0;
    check("b_dual_hit", hit_b, 2'b11);
    check("b_dual_score", score_b, 2);
    check("b_dual_streak", streak_b, 2);
    check("b_dual_act", act_b, 2'b00);
    check("b_dual_y", y_b, {10'd480, 10'd480});
    check("b_dual_miss", miss_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_lane_engine.md
# ddr_lane_engine

Parametrised gameplay core for the DDR display: tracks one scrolling arrow per lane, spawns arrows on a frame cadence, moves them up each frame, judges debounced button presses against a target line, and keeps score, streak and miss counts. Sits between the debounce/frame-strobe logic and the pixel painter in the pixel-clock domain; the painter reads the per-lane Y positions and active flags directly.

## Interface
- LANES, 4, number of arrow lanes (1-8)
- CORDW, 10, coordinate width in bits
- Y_START, 480, Y loaded into a freshly spawned arrow
- SPEED, 7, pixels moved up per frame strobe
- TARGET_Y, 40, Y of the judgement line
- HIT_WIN, 12, hit accepted when |y - TARGET_Y| <= HIT_WIN
- SPAWN_GAP, 20, frames between spawn attempts (>= 1)
- SCOREW, 12, score and streak width
- MAX_MISS, 8, misses that end the game (1-255)
- clk_i  in  1  pixel clock; the only clock
- reset_ni  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle pulse; starts a game from IDLE or OVER
- frame_i  in  1  one-cycle strobe at start of vertical blanking
- btn_i  in  LANES  one-cycle debounced press pulses, bit n = lane n
- arrow_y_o  out  LANES*CORDW  packed Y per lane, lane 0 in LSBs
- arrow_active_o  out  LANES  lane holds a live arrow
- score_o  out  SCOREW  hits this game, saturating
- streak_o  out  SCOREW  consecutive hits, saturating, cleared on miss
- miss_cnt_o  out  8  misses this game
- hit_o  out  LANES  one-cycle pulse per judged hit
- miss_o  out  LANES  one-cycle pulse per miss (bad press or expiry)
- game_over_o  out  1  high in OVER

## Operation
- States: IDLE, PLAY, OVER. IDLE -start_i-> PLAY; PLAY -(miss_cnt reaches MAX_MISS)-> OVER; OVER -start_i-> PLAY. No other transitions.
- Entering PLAY: all lanes inactive, Y = Y_START, score/streak/miss_cnt = 0, spawn counter = 0, lane selector = 0.
- In IDLE/OVER: frame_i and btn_i ignored; arrows frozen; counters hold.
- Per frame_i in PLAY, per active lane: if y < SPEED + 1 -> expire (inactive, miss); else y <= y - SPEED. Inactive lanes hold.
- Spawn: counter increments per frame_i; at SPAWN_GAP-1 it wraps to 0 and the selected lane is spawned (active, y = Y_START). Selected lane already active -> spawn dropped, selector still advances. A lane spawned this frame does not move this frame.
- Press on lane n in PLAY: active and within window -> hit (inactive, y = Y_START, score+1, streak+1); active outside window or inactive -> miss (inactive lanes stay inactive; active lane keeps scrolling).
- Press and frame in same cycle, same lane: judge against pre-move y; a hit suppresses the move and any expiry.
- Multiple lanes same cycle: score += number of hits; miss_cnt += number of misses (saturate at MAX_MISS); any miss clears streak, even with concurrent hits.
- Window arithmetic at CORDW+1 bits signed; no wrap.

## Timing
- Reset (async assert, sync release) and IDLE: all outputs 0 except arrow_y_o = Y_START per lane.
- All outputs registered; hit_o/miss_o/score_o/arrow_*_o update the cycle after the causing frame_i/btn_i edge.
- game_over_o rises the cycle after the miss that reaches MAX_MISS; pulses of that cycle still emitted.
- start_i during PLAY ignored. reset_ni mid-game returns to IDLE immediately.

## Configuration
- DDR_LFSR_SPAWN_EN defined: spawn lane from 8-bit Galois LFSR (taps 0xB8, seed 0x01 at PLAY entry) modulo LANES, advanced once per spawn attempt.
- Undefined: round-robin selector 0,1,...,LANES-1,0...

## Test plan
- Reset, start_i, 20 frames (defaults, round-robin) -> lane 0 active at frame 20 with y=480; frame 21 -> y=473.
- Lane 0 after 63 moves (y=39), btn_i=0001 -> hit_o=0001, score 1, streak 1, lane 0 inactive.
- Lane 0 at y=473, press -> miss_o=0001, miss_cnt 1, streak 0, lane keeps scrolling to 466 next frame.
- Arrow never pressed -> at y=4 next frame miss_o pulses, lane inactive; 8 such misses -> game_over_o=1, further frames freeze state.
- Lanes 0 and 1 both in window, btn_i=0011 same cycle as frame_i -> score +2, no move applied, both inactive.
- Spawn lands on active lane (SPAWN_GAP=1, LANES=1) -> arrow unaffected; LFSR build gives repeatable lane sequence from seed 0x01.
